regbank_write_queue: RTL and testbench
======================================

// Module: regbank_write_queue
// PURPOSE
//  Write-back stage directly upstream of the 16x16 register bank. Queues ALU write requests
//  (dest register + result) in a small FIFO and issues one per cycle as a one-hot regEnable
//  plus ALUBus value. Lets the ALU run ahead of a stalled write-back port. Reports whether a
//  queued or issuing write targets a given register, for RAW-hazard stalling in decode.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of 2, >= 2
//  WIDTH  16  data width; matches register bank width
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-low; 0 clears the block on the next edge
//  wr_valid    in   1          write request valid
//  wr_ready    out  1          queue can accept; a write is accepted when valid & ready at the edge
//  wr_addr     in   4          destination register 0..15
//  wr_data     in   WIDTH      value to write
//  hold        in   1          1 = suspend issue to the bank (queue keeps accepting while not full)
//  ALUBus      out  WIDTH      data to the register bank, registered
//  regEnable   out  16         one-hot write enable to the register bank, or all-zero; registered
//  rd_addr     in   4          hazard query address
//  rd_pending  out  1          combinational: a write to rd_addr is queued or issuing
//  count       out  clog2(DEPTH)+1  queued entries, excluding the issuing entry
// BEHAVIOUR
//  - Reset (reset==0 at edge): rd/wr pointers=0, count=0, regEnable=0, ALUBus=0. Queued and
//    issuing writes are discarded; none reach the bank. wr_ready=0 while reset==0.
//  - wr_ready = reset & (count < DEPTH). It depends only on registered state, never on pop.
//  - Push: wr_valid & wr_ready -> store {wr_addr, wr_data} at wr_ptr; wr_ptr wraps mod DEPTH.
//  - Pop/issue: at each edge with hold==0 & count>0, the head entry loads the output register:
//    regEnable <= 1<<addr, ALUBus <= data, rd_ptr advances with wrap.
//  - Otherwise regEnable <= 0 and ALUBus holds its last value.
//  - regEnable is high for exactly one cycle per issued entry. The bank captures on the next
//    edge.
//  - Latency: push at edge N (empty queue, hold 0) -> regEnable valid in cycle after N+1 ->
//    bank updated at edge N+2. No bypass from input to output.
//  - Simultaneous push and pop: count unchanged, both pointers advance. Push into a full queue
//    is impossible (ready=0). Pop from empty: no-op.
//  - Order preserved. Repeated writes to one register issue in order, so the last one wins.
//  - rd_pending = OR over valid queue entries of (addr==rd_addr), OR (regEnable[rd_addr]==1).
//    An entry counts as valid iff its index is within count of rd_ptr (modular).
//  - Writes to r0 are not special: they issue like any other register.
//  - hold asserted mid-stream: an entry already in the output register still completes its
//    single cycle. No further pops occur until hold drops.
// TESTING
//  - Reset low 2 cycles with wr_valid=1 -> wr_ready=0, regEnable=0, ALUBus=0, count=0.
//    Release reset -> wr_ready=1.
//  - Push {3,16'hBEEF} at edge 0, hold=0 -> regEnable=16'h0008, ALUBus=BEEF in cycle 1 only;
//    regEnable=0 in cycle 2.
//  - hold=1, push 4 writes (r1..r4 = 1..4) -> count=4, wr_ready=0, 5th valid ignored.
//    Drop hold -> regEnable 0002,0004,0008,0010 on 4 consecutive cycles with ALUBus=1..4.
//  - Queue holds r5; rd_addr=5 -> rd_pending=1; rd_addr=6 -> 0. After r5 issues and
//    regEnable clears -> rd_pending=0.
//  - Full queue, hold=0, wr_valid=1 continuously -> one pop per cycle; wr_ready reasserts the
//    cycle after the first pop; count stays DEPTH-1..DEPTH; pointer wrap with no loss or
//    reorder over 12 writes.
//  - Queue with 3 entries, reset=0 for one edge -> all discarded; regEnable=0 thereafter;
//    bank contents unchanged.

Source files
------------

// File: rtl/regbank_write_queue.sv
// Write-back queue feeding the 16x16 register bank: buffers ALU results and issues one
// registered one-hot write per cycle, with a RAW-hazard lookup for the decode stage.
module regbank_write_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [3:0]                 wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       hold,
    output logic [WIDTH-1:0]           ALUBus,
    output logic [15:0]                regEnable,
    input  logic [3:0]                 rd_addr,
    output logic                       rd_pending,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]       addrMem_q [DEPTH];
    logic [WIDTH-1:0] dataMem_q [DEPTH];

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      regEnable_q, regEnable_d;
    logic [WIDTH-1:0] aluBus_q, aluBus_d;

    logic push;
    logic pop;
    logic pendHit;

    // Ready looks only at registered state so it never combinationally depends on pop.
    assign wr_ready = reset & (count_q < CW'(DEPTH));
    assign push     = wr_valid & wr_ready;
    assign pop      = ~hold & (count_q != '0);

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        regEnable_d = '0;
        aluBus_d    = aluBus_q;

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d     = rdPtr_q + 1'b1;
            regEnable_d = 16'h0001 << addrMem_q[rdPtr_q];
            aluBus_d    = dataMem_q[rdPtr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            regEnable_q <= '0;
            aluBus_q    <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            regEnable_q <= regEnable_d;
            aluBus_q    <= aluBus_d;
        end
    end

    // Storage needs no reset: entries are only visible through count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= wr_addr;
            dataMem_q[wrPtr_q] <= wr_data;
        end
    end

    // Hazard: any entry within count of the read pointer, or the write currently issuing.
    always_comb begin
        pendHit = regEnable_q[rd_addr];
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addrMem_q[rdPtr_q + AW'(i)] == rd_addr)) begin
                pendHit = 1'b1;
            end
        end
    end

    assign rd_pending = pendHit;
    assign regEnable  = regEnable_q;
    assign ALUBus     = aluBus_q;
    assign count      = count_q;

endmodule

// File: tb/tb_regbank_write_queue.sv
// Directed bench for regbank_write_queue: reset, single issue, hold/fill/drain, hazard
// lookup, full-rate streaming with pointer wrap, and reset discarding queued writes.
module tb_regbank_write_queue;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hold;
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic [3:0]  rd_addr;
    logic        rd_pending;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    regbank_write_queue #(.DEPTH(4), .WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hold       (hold),
        .ALUBus     (ALUBus),
        .regEnable  (regEnable),
        .rd_addr    (rd_addr),
        .rd_pending (rd_pending),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [15:0] d,
                                 input logic h);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        hold     = h;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [3:0]  tblAddr [12];
    logic [15:0] tblData [12];

    initial begin
        int sent;
        int issued;
        int modelCount;
        int cyc;
        logic readyBefore;
        logic pushed;
        logic popped;
        logic [15:0] expOneHot;

        for (int i = 0; i < 12; i++) begin
            tblAddr[i] = 4'((i * 5 + 2) % 16);
            tblData[i] = 16'hA000 + 16'(i);
        end

        // Reset held low with a request pending
        reset   = 1'b0;
        rd_addr = 4'd0;
        applyStimulus(1'b1, 4'd7, 16'h1234, 1'b0);
        step();
        step();
        checkOutput("resetReady", 32'(wr_ready), 32'd0);
        checkOutput("resetRegEnable", 32'(regEnable), 32'h0);
        checkOutput("resetAluBus", 32'(ALUBus), 32'h0);
        checkOutput("resetCount", 32'(count), 32'd0);

        reset = 1'b1;
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
        #1;
        checkOutput("releaseReady", 32'(wr_ready), 32'd1);

        // Single write: visible one cycle after the push edge, for one cycle only
        applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
        checkOutput("singleNoBypass", 32'(regEnable), 32'h0);
        checkOutput("singleCount", 32'(count), 32'd1);
        step();
        checkOutput("singleRegEnable", 32'(regEnable), 32'h0008);
        checkOutput("singleAluBus", 32'(ALUBus), 32'hBEEF);
        step();
        checkOutput("singleCleared", 32'(regEnable), 32'h0);
        checkOutput("singleAluHold", 32'(ALUBus), 32'hBEEF);

        // Fill under hold, overflow attempt, then drain in order
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 4'(i), 16'(i), 1'b1);
            step();
        end
        checkOutput("fillCount", 32'(count), 32'd4);
        checkOutput("fillReady", 32'(wr_ready), 32'd0);
        checkOutput("fillHoldNoIssue", 32'(regEnable), 32'h0);
        applyStimulus(1'b1, 4'd9, 16'h0099, 1'b1);
        step();
        checkOutput("overflowCount", 32'(count), 32'd4);
        rd_addr = 4'd3;
        #1;
        checkOutput("pendQueuedR3", 32'(rd_pending), 32'd1);
        rd_addr = 4'd9;
        #1;
        checkOutput("pendRejectedR9", 32'(rd_pending), 32'd0);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            expOneHot = 16'h0001 << i;
            checkOutput("drainRegEnable", 32'(regEnable), 32'(expOneHot));
            checkOutput("drainAluBus", 32'(ALUBus), 32'(i));
        end
        step();
        checkOutput("drainDone", 32'(regEnable), 32'h0);
        checkOutput("drainEmpty", 32'(count), 32'd0);

        // Hazard lookup: queued, issuing, then retired
        applyStimulus(1'b1, 4'd5, 16'h0055, 1'b1);
        step();
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b1);
        rd_addr = 4'd5;
        #1;
        checkOutput("pendQueuedR5", 32'(rd_pending), 32'd1);
        rd_addr = 4'd6;
        #1;
        checkOutput("pendOtherR6", 32'(rd_pending), 32'd0);
        rd_addr = 4'd5;
        hold    = 1'b0;
        step();
        checkOutput("pendIssueEnable", 32'(regEnable), 32'h0020);
        checkOutput("pendIssuingR5", 32'(rd_pending), 32'd1);
        step();
        checkOutput("pendRetiredR5", 32'(rd_pending), 32'd0);

        // Full queue streaming with continuous valid: 12 writes, pointers wrap three times
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, tblAddr[sent], tblData[sent], 1'b1);
            step();
            sent++;
        end
        checkOutput("streamFull", 32'(count), 32'd4);
        modelCount = 4;
        issued     = 0;
        cyc        = 0;
        while (issued < 12 && cyc < 40) begin
            applyStimulus(sent < 12, tblAddr[(sent < 12) ? sent : 0],
                          tblData[(sent < 12) ? sent : 0], 1'b0);
            #1;
            readyBefore = wr_ready;
            pushed      = (sent < 12) && readyBefore;
            popped      = (modelCount > 0);
            step();
            if (pushed) sent++;
            modelCount = modelCount + (pushed ? 1 : 0) - (popped ? 1 : 0);
            checkOutput("streamCount", 32'(count), 32'(modelCount));
            if (cyc == 0) begin
                checkOutput("streamReadyBack", 32'(wr_ready), 32'd1);
            end
            if (popped) begin
                expOneHot = 16'h0001 << tblAddr[issued];
                checkOutput("streamRegEnable", 32'(regEnable), 32'(expOneHot));
                checkOutput("streamAluBus", 32'(ALUBus), 32'(tblData[issued]));
                issued++;
            end else begin
                checkOutput("streamIdle", 32'(regEnable), 32'h0);
            end
            cyc++;
        end
        checkOutput("streamAllIssued", 32'(issued), 32'd12);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
        step();
        checkOutput("streamDrained", 32'(regEnable), 32'h0);

        // Reset discards three queued writes
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 4'(i), 16'h7700 + 16'(i), 1'b1);
            step();
        end
        checkOutput("discardFill", 32'(count), 32'd3);
        applyStimulus(1'b0, 4'd0, 16'h0, 1'b0);
        reset = 1'b0;
        step();
        checkOutput("discardCount", 32'(count), 32'd0);
        checkOutput("discardReadyLow", 32'(wr_ready), 32'd0);
        checkOutput("discardRegEnable", 32'(regEnable), 32'h0);
        reset   = 1'b1;
        rd_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("discardNoIssue", 32'(regEnable), 32'h0);
        end
        checkOutput("discardNoPending", 32'(rd_pending), 32'd0);
        checkOutput("discardAluBus", 32'(ALUBus), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
